// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its output queue.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  localparam int PC_INC      = 4;
  localparam int QUEUE_DEPTH = 2;
  localparam int PTR_W       = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int COUNT_W     = $clog2(QUEUE_DEPTH + 1);

endpackage

// File: rtl/fetch_queue.sv
// Small in-order queue of {pc, instr} entries between fetch and decode.
// A push is accepted while full if a pop happens in the same cycle; flush empties it.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DW = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               push,
  input  logic [DW-1:0]      push_data,
  input  logic               pop,
  output logic [COUNT_W-1:0] count,
  output logic [DW-1:0]      head_data
);

  logic [DW-1:0]    mem [QUEUE_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == COUNT_W'(QUEUE_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: contents are only visible through a nonzero count.
  always_ff @(posedge clk) begin
    if (do_push && !reset && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: walks pc through imem, queues {pc, instr} for decode,
// honours halt and redirect requests.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               SIZE     = 23,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt_req,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_instr,
  output logic [WIDTH-1:0] out_pc,
  output fetch_state_e     dbg_state,
  output logic [SIZE-3:0]  dbg_imem_index
);

  fetch_state_e         state;
  fetch_state_e         state_next;
  logic [WIDTH-1:0]     pc;
  logic [WIDTH-1:0]     pc_next;
  logic                 push;
  logic                 pop;
  logic                 q_full;
  logic [COUNT_W-1:0]   q_count;
  logic [2*WIDTH-1:0]   q_head;

  // Handshake: an entry transfers to decode on a cycle where out_valid and
  // out_ready are both high; out_valid never depends on out_ready, and a
  // redirect in the same cycle cancels the transfer (the queue is flushed).
  assign out_valid = (q_count != '0);
  assign q_full    = (q_count == COUNT_W'(QUEUE_DEPTH));
  assign pop       = out_valid && out_ready && !redirect_valid;
  assign push      = (state == ST_FETCH) && !halt_req && !redirect_valid
                     && (!q_full || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    case (state)
      ST_IDLE, ST_HALTED: if (start)    state_next = ST_FETCH;
      ST_FETCH:           if (halt_req) state_next = ST_HALTED;
      default:                          state_next = ST_IDLE;
    endcase
    if (redirect_valid)  pc_next = {redirect_pc[WIDTH-1:2], 2'b00};
    else if (push)       pc_next = pc + WIDTH'(PC_INC);
  end

  fetch_queue #(
    .DW (2*WIDTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({pc, imem_rdata}),
    .pop       (pop),
    .count     (q_count),
    .head_data (q_head)
  );

  assign {out_pc, out_instr} = q_head;
  assign imem_addr      = pc;
  assign dbg_state      = state;
  assign dbg_imem_index = pc[SIZE-1:2];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: scoreboard queue of expected {pc, instr}
// checked by a monitor on every decode handshake, plus direct state checks.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int WIDTH = 32;
  localparam int SIZE  = 23;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              halt_req;
  logic              redirect_valid;
  logic [WIDTH-1:0]  redirect_pc;
  logic [WIDTH-1:0]  imem_addr;
  logic [WIDTH-1:0]  imem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_instr;
  logic [WIDTH-1:0]  out_pc;
  fetch_state_e      dbg_state;
  logic [SIZE-3:0]   dbg_imem_index;

  logic [2*WIDTH-1:0] exp_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  fetch_unit #(
    .WIDTH    (WIDTH),
    .SIZE     (SIZE),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .halt_req       (halt_req),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .dbg_state      (dbg_state),
    .dbg_imem_index (dbg_imem_index)
  );

  // Instruction memory contents, combinational read.
  function automatic logic [WIDTH-1:0] imem_word(input logic [WIDTH-1:0] a);
    case (a)
      32'h0000_0000: return 32'hE080_0001;
      32'h0000_0004: return 32'hE241_1001;
      default:       return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  assign imem_rdata = imem_word(imem_addr);

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic expect_pc(input logic [WIDTH-1:0] pc);
    exp_q.push_back({pc, imem_word(pc)});
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset && !redirect_valid && out_valid && out_ready) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL deliver: got pc=%h instr=%h, expected no delivery", out_pc, out_instr);
      end else begin
        logic [2*WIDTH-1:0] e;
        e = exp_q.pop_front();
        if ({out_pc, out_instr} !== e) begin
          tests_failed++;
          $display("FAIL deliver: got pc=%h instr=%h, expected pc=%h instr=%h",
                   out_pc, out_instr, e[2*WIDTH-1:WIDTH], e[WIDTH-1:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; start = 1'b0; halt_req = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    sample();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_pc",    64'(out_pc),    64'd0);
    check("rst_instr", 64'(out_instr), 64'd0);
    check("rst_addr",  64'(imem_addr), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));

    // Basic fetch and throughput, then halt.
    tick();
    out_ready = 1'b1;
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8); expect_pc(32'hC);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    sample();
    check("first_valid", 64'(out_valid), 64'd1);
    check("first_pc",    64'(out_pc),    64'd0);
    tick(); tick(); tick();
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    sample();
    check("halt_state", 64'(dbg_state), 64'(ST_HALTED));
    check("halt_valid", 64'(out_valid), 64'd0);
    check("halt_addr",  64'(imem_addr), 64'h10);
    tick(); tick();
    sample();
    check("halt_frozen", 64'(imem_addr), 64'h10);

    // Backpressure: queue fills, pc holds, then drains in order under halt.
    tick();
    reset = 1'b1; out_ready = 1'b0; tick(); reset = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    sample();
    check("bp_addr",  64'(imem_addr), 64'h8);
    check("bp_valid", 64'(out_valid), 64'd1);
    check("bp_pc",    64'(out_pc),    64'h0);
    check("bp_instr", 64'(out_instr), 64'hE080_0001);
    tick();
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8); expect_pc(32'hC);
    out_ready = 1'b1;
    tick(); tick();
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    tick();
    sample();
    check("drain_valid", 64'(out_valid), 64'd0);
    check("drain_state", 64'(dbg_state), 64'(ST_HALTED));
    check("drain_addr",  64'(imem_addr), 64'h10);

    // Resume from frozen pc, then redirect while full.
    tick();
    out_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    sample();
    check("resume_pc",   64'(out_pc),    64'h10);
    check("resume_addr", 64'(imem_addr), 64'h18);
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h43; tick(); redirect_valid = 1'b0;
    sample();
    check("redir_valid", 64'(out_valid),      64'd0);
    check("redir_addr",  64'(imem_addr),      64'h40);
    check("redir_index", 64'(dbg_imem_index), 64'h10);
    check("redir_state", 64'(dbg_state),      64'(ST_FETCH));
    expect_pc(32'h40); expect_pc(32'h44);
    tick();
    out_ready = 1'b1;
    tick();
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    sample();
    check("redir_halt_valid", 64'(out_valid), 64'd0);
    check("redir_halt_addr",  64'(imem_addr), 64'h48);

    // Redirect in HALTED keeps the state; pc wraps past the top of the space.
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; tick(); redirect_valid = 1'b0;
    sample();
    check("wrap_state", 64'(dbg_state), 64'(ST_HALTED));
    check("wrap_addr",  64'(imem_addr), 64'hFFFF_FFFC);
    expect_pc(32'hFFFF_FFFC); expect_pc(32'h0);
    tick();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    sample();
    check("wrap_after_addr",  64'(imem_addr), 64'h4);
    check("wrap_after_valid", 64'(out_valid), 64'd0);

    // start+halt together in FETCH, then reset with a full queue.
    tick();
    out_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    start = 1'b1; halt_req = 1'b1; tick(); start = 1'b0; halt_req = 1'b0;
    sample();
    check("sh_state", 64'(dbg_state), 64'(ST_HALTED));
    check("sh_valid", 64'(out_valid), 64'd1);
    check("sh_addr",  64'(imem_addr), 64'hC);
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    out_ready = 1'b1;
    sample();
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_addr",  64'(imem_addr), 64'h0);
    check("mid_rst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("mid_rst_pc",    64'(out_pc),    64'd0);
    check("mid_rst_instr", 64'(out_instr), 64'd0);
    tick(); tick();
    sample();
    check("idle_valid", 64'(out_valid), 64'd0);

    // ---------------- report ----------------
    check("scoreboard_left", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning instruction/PC width in bits.
REQ-002 SHALL have parameter SIZE, default 23, meaning imem address span; imem word index is pc[SIZE-1:2].
REQ-003 SHALL have parameter RESET_PC, default 0, meaning PC loaded on reset.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  leave IDLE/HALTED and begin fetching.
REQ-007 halt_req  input  1  stop issuing new fetches.
REQ-008 redirect_valid  input  1  branch/redirect request.
REQ-009 redirect_pc  input  WIDTH  redirect target.
REQ-010 imem_addr  output  WIDTH  byte address to imem, equal to current pc.
REQ-011 imem_rdata  input  WIDTH  imem read data, combinational, same cycle as imem_addr.
REQ-012 out_valid  output  1  head queue entry valid toward decode.
REQ-013 out_ready  input  1  decode accepts head entry.
REQ-014 out_instr  output  WIDTH  head entry instruction.
REQ-015 out_pc  output  WIDTH  head entry PC.

Function
REQ-016 SHALL implement states IDLE, FETCH, HALTED; IDLE->FETCH and HALTED->FETCH on start; FETCH->HALTED on halt_req.
REQ-017 In FETCH, SHALL push {pc, imem_rdata} into a 2-entry in-order queue and advance pc by 4 whenever the queue is not full or a pop occurs the same cycle.
REQ-018 SHALL not push and SHALL hold pc in IDLE, HALTED, or when queue full with no pop.
REQ-019 Pop SHALL occur when out_valid and out_ready are both high; out_valid SHALL equal (count != 0).
REQ-020 Latency: start at cycle N -> FETCH at N+1 -> out_valid high at N+2 with out_pc=RESET_PC.
REQ-021 Sustained throughput SHALL be one instruction per cycle while out_ready stays high.
REQ-022 redirect_valid SHALL have priority over push, pop and halt_req: queue emptied, pc <= {redirect_pc[WIDTH-1:2], 2'b00}, no push that cycle, out_valid low next cycle.
REQ-023 redirect SHALL be honoured in every state without changing state, except halt_req in the same cycle still moves FETCH->HALTED.
REQ-024 halt_req SHALL take effect before push in the same cycle (no push); queued entries SHALL still drain in HALTED.
REQ-025 start and halt_req together in FETCH SHALL give HALTED; start is ignored in FETCH.
REQ-026 pc SHALL wrap modulo 2^WIDTH (0xFFFFFFFC+4 -> 0x00000000).
REQ-027 out_instr/out_pc SHALL be 0 when queue empty.

Reset
REQ-028 On reset: state IDLE, pc=RESET_PC, count=0, out_valid=0, out_instr=0, out_pc=0, imem_addr=RESET_PC.
REQ-029 Reset mid-operation SHALL discard all queued entries and pending redirects in the same edge; reset overrides every other input.

Structure
REQ-030 Package fetch_pkg SHALL hold the state enum, PC_INC=4 and QUEUE_DEPTH=2.
REQ-031 The queue SHALL be a sub-module fetch_queue (2 entries, push/pop/flush, count, same-cycle push+pop when full).

Verification
REQ-032 Reset, start, out_ready=1, imem holds 0xE0800001 at 0x0, 0xE2411001 at 0x4 -> out_valid at cycle 2 with pc 0x0, then pc 0x4 next cycle.
REQ-033 out_ready=0 for 5 cycles after start -> queue holds pcs 0x0,0x4; pc stays 0x8; release -> 0x0,0x4,0x8 delivered in order, no loss or duplicate.
REQ-034 redirect_valid with redirect_pc=0x43 while queue full -> out_valid low next cycle; next delivered out_pc=0x40.
REQ-035 halt_req with 2 entries queued, out_ready=1 -> both drain, no further push, imem_addr frozen; start -> fetching resumes from frozen pc.
REQ-036 redirect to 0xFFFFFFFC -> delivered pcs 0xFFFFFFFC then 0x00000000.
REQ-037 reset asserted with 2 entries queued -> next cycle out_valid=0, pc=RESET_PC, state IDLE.
